// File: rtl/msx_mouse_pkg.sv
// Shared types and default timing for the MSX joystick-port mouse reader.
package msx_mouse_pkg;

  typedef enum logic [2:0] {
    WAIT_GAP,
    IDLE,
    STROBE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  typedef logic [1:0] nib_idx_t;

  localparam int unsigned DEF_SETTLE_CYC   = 43;
  localparam int unsigned DEF_GAP_CYC      = 43000;
  localparam int unsigned DEF_POLL_CYC     = 357955;
  localparam int unsigned DEF_PRESENT_MISS = 4;

  localparam logic [15:0] ALL_ONES_DELTA = 16'hFFFF;
  localparam nib_idx_t    LAST_NIB       = 2'd3;

endpackage

// File: rtl/msx_mouse_delay_cnt.sv
// Loadable down-counter that stops at zero; done_o is high while the count is zero.
module msx_mouse_delay_cnt #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= WIDTH'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/msx_mouse_reader.sv
// MSX mouse initiator: strobes pin 8, samples four nibbles and assembles signed X/Y deltas.
module msx_mouse_reader
  import msx_mouse_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int unsigned GAP_CYC      = DEF_GAP_CYC,
  parameter int unsigned POLL_CYC     = DEF_POLL_CYC,
  parameter int unsigned PRESENT_MISS = DEF_PRESENT_MISS
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  output logic       strobe,
  input  logic [5:0] data,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn,
  output logic       valid,
  output logic       busy,
  output logic       present
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC);
  localparam int unsigned GAP_W    = $clog2(GAP_CYC);
  localparam int unsigned POLL_W   = $clog2(POLL_CYC);
  localparam int unsigned MISS_W   = $clog2(PRESENT_MISS + 1);

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);
  localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(PRESENT_MISS);

  state_e              state_q, state_d;
  nib_idx_t            nib_q, nib_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [11:0]         shift_q, shift_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [7:0]          dx_q, dx_d, dy_q, dy_d;
  logic [1:0]          btn_q, btn_d;
  logic                strobe_q, strobe_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                present_q, present_d;
  logic                settle_load, settle_done;
  logic                gap_load, gap_done;
  logic                trigger_w;
  logic [15:0]         frame_w;

  msx_mouse_delay_cnt #(
    .WIDTH     (SETTLE_W),
    .RESET_VAL (0)
  ) u_settle_cnt (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .load_i     (settle_load),
    .load_val_i (SETTLE_W'(SETTLE_CYC - 1)),
    .done_o     (settle_done)
  );

  // Reset preloads the gap so a frame cut short by reset is followed by a full idle gap.
  msx_mouse_delay_cnt #(
    .WIDTH     (GAP_W),
    .RESET_VAL (GAP_CYC - 1)
  ) u_gap_cnt (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(GAP_CYC - 1)),
    .done_o     (gap_done)
  );

  assign trigger_w = start | (enable & (poll_q == POLL_LAST));
  assign frame_w   = {shift_q, data[3:0]};

  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    poll_d      = (poll_q == POLL_LAST) ? poll_q : poll_q + POLL_W'(1);
    shift_d     = shift_q;
    miss_d      = miss_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    btn_d       = btn_q;
    strobe_d    = strobe_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    present_d   = present_q;
    settle_load = 1'b0;
    gap_load    = 1'b0;

    unique case (state_q)
      WAIT_GAP: begin
        strobe_d = 1'b0;
        if (gap_done) state_d = IDLE;
      end
      IDLE: begin
        strobe_d = 1'b0;
        if (trigger_w) begin
          poll_d  = '0;
          nib_d   = '0;
          busy_d  = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        strobe_d    = ~nib_q[0];
        settle_load = 1'b1;
        state_d     = SETTLE;
      end
      SETTLE: begin
        if (settle_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        shift_d = frame_w[11:0];
        if (nib_q == LAST_NIB) begin
          dx_d    = frame_w[15:8];
          dy_d    = frame_w[7:0];
          btn_d   = ~data[5:4];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          if (frame_w != ALL_ONES_DELTA) begin
            present_d = 1'b1;
            miss_d    = '0;
          end else begin
            if (miss_q != MISS_LIMIT) miss_d = miss_q + MISS_W'(1);
            if (miss_q >= MISS_LIMIT - MISS_W'(1)) present_d = 1'b0;
          end
          state_d = DONE;
        end else begin
          nib_d   = nib_q + 2'd1;
          state_d = STROBE;
        end
      end
      DONE: begin
        gap_load = 1'b1;
        state_d  = WAIT_GAP;
      end
      default: state_d = WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= WAIT_GAP;
      nib_q     <= '0;
      poll_q    <= '0;
      shift_q   <= '0;
      miss_q    <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      btn_q     <= '0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      present_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      poll_q    <= poll_d;
      shift_q   <= shift_d;
      miss_q    <= miss_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      btn_q     <= btn_d;
      strobe_q  <= strobe_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      present_q <= present_d;
    end
  end

  assign strobe  = strobe_q;
  assign dx      = dx_q;
  assign dy      = dy_q;
  assign btn     = btn_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign present = present_q;

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Bench for msx_mouse_reader: behavioural mouse/joystick responder plus frame-level reference model.
module tb_msx_mouse_reader;

  localparam int S       = 5;
  localparam int GAP     = 60;
  localparam int POLL    = 200;
  localparam int PM      = 4;
  localparam int TIMEOUT = 40;
  localparam int LAT     = 4 * (S + 2) + 1;

  logic       clk_sys = 1'b0;
  logic       reset, enable, start;
  logic [5:0] data;
  logic       strobe, valid, busy, present;
  logic [7:0] dx, dy;
  logic [1:0] btn;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  msx_mouse_reader #(
    .SETTLE_CYC   (S),
    .GAP_CYC      (GAP),
    .POLL_CYC     (POLL),
    .PRESENT_MISS (PM)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .enable  (enable),
    .start   (start),
    .strobe  (strobe),
    .data    (data),
    .dx      (dx),
    .dy      (dy),
    .btn     (btn),
    .valid   (valid),
    .busy    (busy),
    .present (present)
  );

  // Responder: every strobe edge advances the nibble; a long quiet period restarts at nibble 0.
  logic [7:0]  r_x = 8'h00, r_y = 8'h00;
  logic [1:0]  r_btn_n = 2'b11;
  bit          joy = 1'b1;
  int          r_idx = 0;
  int          r_since = 1000;
  logic        r_prev = 1'b0;
  logic [15:0] r_frame;

  initial begin
    data = 6'h3F;
    forever begin
      @(negedge clk_sys);
      if (strobe !== r_prev) begin
        if (r_since > TIMEOUT) r_idx = 0;
        else if (r_idx < 3) r_idx++;
        r_since = 0;
        r_prev  = strobe;
      end else if (r_since < 100000) begin
        r_since++;
      end
      if (joy) begin
        data = 6'h3F;
      end else begin
        r_frame = {r_x, r_y};
        data = {r_btn_n, r_frame[15-4*r_idx -: 4]};
      end
    end
  end

  // Presence model: once a real mouse frame is seen, PM consecutive all-ones frames clear it.
  bit m_seen = 1'b0;
  int m_ones = 0;

  task automatic model_reset();
    m_seen = 1'b0;
    m_ones = 0;
  endtask

  function automatic bit model_frame(logic [15:0] f);
    if (f != 16'hFFFF) begin
      m_seen = 1'b1;
      m_ones = 0;
    end else begin
      m_ones++;
    end
    return m_seen && (m_ones < PM);
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Pulses start and follows the frame: latency to valid, strobe edge count and edge values.
  task automatic run_frame(output int lat, output int nedge, output logic [3:0] seq, input bit poke_mid);
    logic prev;
    lat   = -1;
    nedge = 0;
    seq   = '0;
    @(negedge clk_sys);
    prev  = strobe;
    start = 1'b1;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk_sys);
      start = poke_mid && (k == 10);
      if (strobe !== prev) begin
        if (nedge < 4) seq[3-nedge] = strobe;
        nedge++;
        prev = strobe;
      end
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int str_hi, busy_hi;
    reset = 1'b1; enable = 1'b0; start = 1'b0; joy = 1'b1;
    idle_cycles(4);
    checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", strobe); end
    checks++; if ({dx, dy} !== 16'h0000) begin errors++; $display("FAIL reset_delta: got %h want 0000", {dx, dy}); end
    checks++; if (btn !== 2'b00) begin errors++; $display("FAIL reset_btn: got %b want 00", btn); end
    checks++; if ({valid, busy, present} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {valid, busy, present}); end
    model_reset();
    reset = 1'b0;
    str_hi = 0; busy_hi = 0;
    for (int k = 1; k <= GAP + 20; k++) begin
      start = (k == GAP / 2);
      @(negedge clk_sys);
      if (strobe !== 1'b0) str_hi++;
      if (busy !== 1'b0) busy_hi++;
    end
    start = 1'b0;
    checks++; if (str_hi != 0) begin errors++; $display("FAIL gap_strobe_quiet: got %0d high cycles want 0", str_hi); end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL gap_start_ignored: got %0d busy cycles want 0", busy_hi); end
  endtask

  task automatic test_mouse_frame();
    int lat, nedge, busy_hi;
    logic [3:0] seq;
    bit exp_p;
    joy = 1'b0; r_x = 8'h12; r_y = 8'hFE; r_btn_n = 2'b10;
    run_frame(lat, nedge, seq, 1'b1);
    exp_p = model_frame(16'h12FE);
    checks++; if (lat != LAT) begin errors++; $display("FAIL mouse_latency: got %0d want %0d", lat, LAT); end
    checks++; if (nedge != 4 || seq !== 4'b1010) begin errors++; $display("FAIL mouse_strobe_seq: got %0d edges %b want 4 edges 1010", nedge, seq); end
    checks++; if (dx !== 8'h12) begin errors++; $display("FAIL mouse_dx: got %h want 12", dx); end
    checks++; if (dy !== 8'hFE) begin errors++; $display("FAIL mouse_dy: got %h want fe", dy); end
    checks++; if (btn !== 2'b01) begin errors++; $display("FAIL mouse_btn: got %b want 01", btn); end
    checks++; if (present !== exp_p) begin errors++; $display("FAIL mouse_present: got %b want %b", present, exp_p); end
    @(negedge clk_sys);
    checks++; if ({valid, busy, strobe} !== 3'b000) begin errors++; $display("FAIL mouse_after_done: got %b want 000", {valid, busy, strobe}); end
    busy_hi = 0;
    for (int k = 0; k < GAP + 40; k++) begin
      @(negedge clk_sys);
      if (busy !== 1'b0) busy_hi++;
    end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL busy_start_ignored: got %0d busy cycles want 0", busy_hi); end
    checks++; if ({dx, dy} !== 16'h12FE) begin errors++; $display("FAIL mouse_hold: got %h want 12fe", {dx, dy}); end
  endtask

  task automatic test_random_frames();
    int lat, nedge;
    logic [3:0] seq;
    bit exp_p;
    joy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r_x = 8'($urandom); r_y = 8'($urandom); r_btn_n = 2'($urandom);
      if (i == 3) begin r_x = 8'h80; r_y = 8'h7F; end
      run_frame(lat, nedge, seq, 1'b0);
      exp_p = model_frame({r_x, r_y});
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if ({dx, dy} !== {r_x, r_y}) begin errors++; $display("FAIL rand%0d_delta: got %h want %h", i, {dx, dy}, {r_x, r_y}); end
      checks++; if (btn !== ~r_btn_n) begin errors++; $display("FAIL rand%0d_btn: got %b want %b", i, btn, ~r_btn_n); end
      checks++; if (present !== exp_p) begin errors++; $display("FAIL rand%0d_present: got %b want %b", i, present, exp_p); end
      @(negedge clk_sys);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rand%0d_valid_pulse: got %b want 0", i, valid); end
      idle_cycles(GAP + 5);
    end
  endtask

  task automatic test_joystick();
    int lat, nedge;
    logic [3:0] seq;
    bit exp_p;
    joy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      run_frame(lat, nedge, seq, 1'b0);
      exp_p = model_frame(16'hFFFF);
      checks++; if (lat != LAT) begin errors++; $display("FAIL joy%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if ({dx, dy, btn} !== 18'h3FFFC) begin errors++; $display("FAIL joy%0d_data: got %h/%h/%b want ff/ff/00", i, dx, dy, btn); end
      checks++; if (present !== exp_p) begin errors++; $display("FAIL joy%0d_present: got %b want %b", i, present, exp_p); end
      idle_cycles(GAP + 5);
    end
  endtask

  task automatic test_poll();
    int rises[3];
    int nr, k;
    logic prev;
    joy = 1'b0; r_x = 8'h3C; r_y = 8'h05; r_btn_n = 2'b11;
    nr = 0; k = 0; prev = busy;
    enable = 1'b1;
    while (nr < 3 && k < 3 * POLL + 100) begin
      @(negedge clk_sys);
      k++;
      if (busy === 1'b1 && prev !== 1'b1) begin rises[nr] = k; nr++; end
      if (valid === 1'b1) void'(model_frame({r_x, r_y}));
      prev = busy;
    end
    checks++; if (nr != 3) begin errors++; $display("FAIL poll_frames: got %0d want 3", nr); end
    else begin
      checks++; if (rises[1] - rises[0] != POLL) begin errors++; $display("FAIL poll_period_a: got %0d want %0d", rises[1] - rises[0], POLL); end
      checks++; if (rises[2] - rises[1] != POLL) begin errors++; $display("FAIL poll_period_b: got %0d want %0d", rises[2] - rises[1], POLL); end
    end
  endtask

  task automatic test_enable_drop();
    int k, nvalid, nrise;
    logic prev;
    k = 0;
    while (busy !== 1'b1 && k < POLL + 50) begin @(negedge clk_sys); k++; end
    while (strobe !== 1'b1 && k < POLL + 80) begin @(negedge clk_sys); k++; end
    while (strobe !== 1'b0 && k < POLL + 110) begin @(negedge clk_sys); k++; end
    checks++; if (k >= POLL + 110) begin errors++; $display("FAIL drop_reach_nibble1: got timeout after %0d cycles want nibble 1", k); end
    enable = 1'b0;
    nvalid = 0; nrise = 0; prev = busy;
    for (int j = 0; j < 2 * POLL + 50; j++) begin
      @(negedge clk_sys);
      if (valid === 1'b1) begin nvalid++; void'(model_frame({r_x, r_y})); end
      if (busy === 1'b1 && prev !== 1'b1) nrise++;
      prev = busy;
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL drop_valid_count: got %0d want 1", nvalid); end
    checks++; if (nrise != 0) begin errors++; $display("FAIL drop_no_new_frame: got %0d want 0", nrise); end
  endtask

  task automatic test_reset_midframe();
    int k, nrise, nvalid;
    logic prev;
    bit exp_p;
    joy = 1'b0; r_x = 8'($urandom) | 8'h01; r_y = 8'($urandom); r_btn_n = 2'b01;
    @(negedge clk_sys);
    start = 1'b1;
    nrise = 0; k = 0; prev = strobe;
    while (nrise < 2 && k < LAT + 20) begin
      @(negedge clk_sys);
      start = 1'b0;
      k++;
      if (strobe === 1'b1 && prev !== 1'b1) nrise++;
      prev = strobe;
    end
    checks++; if (nrise != 2) begin errors++; $display("FAIL rst_reach_nibble2: got %0d rises want 2", nrise); end
    reset = 1'b1;
    @(negedge clk_sys);
    checks++; if ({strobe, valid, busy} !== 3'b000) begin errors++; $display("FAIL rst_mid_outputs: got %b want 000", {strobe, valid, busy}); end
    reset = 1'b0;
    model_reset();
    start = 1'b1;
    k = 0; nvalid = 0;
    while (busy !== 1'b1 && k < GAP + 50) begin
      @(negedge clk_sys);
      k++;
      if (valid === 1'b1) nvalid++;
    end
    start = 1'b0;
    checks++; if (k < GAP || k > GAP + 2) begin errors++; $display("FAIL rst_gap: got %0d cycles want %0d..%0d", k, GAP, GAP + 2); end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL rst_no_valid: got %0d want 0", nvalid); end
    k = 0;
    while (valid !== 1'b1 && k < LAT + 20) begin @(negedge clk_sys); k++; end
    exp_p = model_frame({r_x, r_y});
    checks++; if ({dx, dy} !== {r_x, r_y}) begin errors++; $display("FAIL rst_next_delta: got %h want %h", {dx, dy}, {r_x, r_y}); end
    checks++; if (present !== exp_p) begin errors++; $display("FAIL rst_next_present: got %b want %b", present, exp_p); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0;
    test_reset();
    test_mouse_frame();
    test_random_frames();
    test_joystick();
    test_poll();
    test_enable_drop();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
